// File: rtl/bcd_convert_pkg.sv
// Shared constants and state encoding for the binary-to-BCD converter.
package bcd_convert_pkg;

    localparam int DIGITS = 10;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_convert_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // A corrected value is at most 9+3=12, so the result always fits a nibble.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_convert.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock)
// with start edge detection, significant-digit count and error pass-through.
module bcd_convert #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = bcd_convert_pkg::DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  err_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [3:0]            ndigits,
    output logic                  err_out
);

    import bcd_convert_pkg::*;

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;

    state_t             state_q, state_d;
    logic               start_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]      sh_q, sh_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic [3:0]         nd_q, nd_d;
    logic               err_q, err_d;

    logic [BW-1:0]      sh_corr;
    logic [SW-1:0]      sh_next;
    logic [BW-1:0]      bcd_next;
    logic [3:0]         nd_calc;
    logic               trig;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .din  (sh_q[WIDTH + 4*g +: 4]),
                .dout (sh_corr[4*g +: 4])
            );
        end
    endgenerate

    // The top bit of the corrected BCD field is always zero (top digit stays below 8), so dropping it is safe.
    assign sh_next  = {sh_corr[BW-2:0], sh_q[WIDTH-1:0], 1'b0};
    assign bcd_next = sh_next[SW-1:WIDTH];

    // Only a fresh rising edge of start seen while idle launches a conversion.
    assign trig = start & ~start_q & (state_q == ST_IDLE);

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign bcd     = bcd_q;
    assign ndigits = nd_q;
    assign err_out = err_q;

    // Significant-digit count of the final result: highest nonzero digit index + 1, never below 1.
    always_comb begin
        nd_calc = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_next[4*i +: 4] != 4'd0) begin
                nd_calc = 4'(i + 1);
            end
        end
    end

    // Next-state logic; result registers only change on the edge that enters DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        nd_d    = nd_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    if (err_in) begin
                        state_d = ST_DONE;
                        bcd_d   = '0;
                        nd_d    = 4'd0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                        sh_d    = {{BW{1'b0}}, bin};
                        cnt_d   = CNT_W'(WIDTH);
                    end
                end
            end
            ST_SHIFT: begin
                sh_d  = sh_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    bcd_d   = bcd_next;
                    nd_d    = nd_calc;
                    err_d   = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            nd_q    <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            nd_q    <= nd_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd_convert.sv
// Directed self-checking bench for bcd_convert.
module tb_bcd_convert;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;

    logic                clk;
    logic                reset;
    logic                start;
    logic [WIDTH-1:0]    bin;
    logic                err_in;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [3:0]          ndigits;
    logic                err_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_edge = 0;
    int pulses = 0;

    bcd_convert #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin     (bin),
        .err_in  (err_in),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd),
        .ndigits (ndigits),
        .err_out (err_out)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; everything is driven and sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Raise start with a value; returns in cycle N+1 where N is the sampling edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] b, input logic e);
        bin    = b;
        err_in = e;
        start  = 1'b1;
        n_edge = cyc;
        step();
    endtask

    // Bounded wait for done, then check its latency relative to the trigger edge.
    task automatic waitDone(input string tag, input int exp_lat);
        int guard;
        guard = 0;
        while (done !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        checkOutput({tag, "_latency"}, 64'(cyc - n_edge), 64'(exp_lat));
    endtask

    task automatic countDone(input int ncyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            step();
            if (done === 1'b1) cnt++;
        end
    endtask

    // Directed sequence covering reset, conversions, level start, error path, glitch and abort.
    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        bin    = '0;
        err_in = 1'b0;
        step();
        step();
        step();
        checkOutput("rst_busy",    64'(busy),    64'd0);
        checkOutput("rst_done",    64'(done),    64'd0);
        checkOutput("rst_bcd",     64'(bcd),     64'd0);
        checkOutput("rst_ndigits", 64'(ndigits), 64'd0);
        checkOutput("rst_err",     64'(err_out), 64'd0);
        reset = 1'b1;
        step();

        $display("[TB] zero input");
        applyStimulus(32'd0, 1'b0);
        checkOutput("zero_busy", 64'(busy), 64'd1);
        waitDone("zero", 33);
        checkOutput("zero_bcd",     64'(bcd),     64'h0);
        checkOutput("zero_ndigits", 64'(ndigits), 64'd1);
        checkOutput("zero_err",     64'(err_out), 64'd0);
        start = 1'b0;
        step();
        checkOutput("zero_done_pulse", 64'(done), 64'd0);
        checkOutput("zero_idle",       64'(busy), 64'd0);

        $display("[TB] all ones");
        applyStimulus(32'hFFFF_FFFF, 1'b0);
        waitDone("max", 33);
        checkOutput("max_bcd",     64'(bcd),     64'h42_9496_7295);
        checkOutput("max_ndigits", 64'(ndigits), 64'd10);
        start = 1'b0;
        step();
        checkOutput("max_bcd_held", 64'(bcd), 64'h42_9496_7295);

        $display("[TB] level start held");
        applyStimulus(32'd12345, 1'b0);
        waitDone("lvl", 33);
        checkOutput("lvl_bcd",     64'(bcd),     64'h00_0001_2345);
        checkOutput("lvl_ndigits", 64'(ndigits), 64'd5);
        countDone(67, pulses);
        checkOutput("lvl_extra_done", 64'(pulses), 64'd0);
        start = 1'b0;
        step();

        $display("[TB] error path");
        applyStimulus(32'd7, 1'b1);
        waitDone("err", 1);
        checkOutput("err_bcd",     64'(bcd),     64'h0);
        checkOutput("err_ndigits", 64'(ndigits), 64'd0);
        checkOutput("err_flag",    64'(err_out), 64'd1);
        start = 1'b0;
        step();
        applyStimulus(32'd3, 1'b0);
        checkOutput("err_held_during_shift", 64'(err_out), 64'd1);
        waitDone("clr", 33);
        checkOutput("clr_err",     64'(err_out), 64'd0);
        checkOutput("clr_bcd",     64'(bcd),     64'h3);
        checkOutput("clr_ndigits", 64'(ndigits), 64'd1);
        start = 1'b0;
        step();

        $display("[TB] start glitch while busy");
        applyStimulus(32'd999, 1'b0);
        for (int i = 0; i < 9; i++) step();
        start = 1'b0;
        bin   = 32'd5;
        step();
        start = 1'b1;
        step();
        waitDone("glitch", 33);
        checkOutput("glitch_bcd",     64'(bcd),     64'h999);
        checkOutput("glitch_ndigits", 64'(ndigits), 64'd3);
        step();
        step();
        step();
        checkOutput("glitch_no_retrig", 64'(busy), 64'd0);
        start = 1'b0;
        step();

        $display("[TB] reset mid-conversion");
        applyStimulus(32'd87654321, 1'b0);
        for (int i = 0; i < 14; i++) step();
        reset = 1'b0;
        start = 1'b0;
        step();
        checkOutput("abort_busy",    64'(busy),    64'd0);
        checkOutput("abort_done",    64'(done),    64'd0);
        checkOutput("abort_bcd",     64'(bcd),     64'd0);
        checkOutput("abort_ndigits", 64'(ndigits), 64'd0);
        checkOutput("abort_err",     64'(err_out), 64'd0);
        reset = 1'b1;
        countDone(40, pulses);
        checkOutput("abort_no_done", 64'(pulses), 64'd0);
        applyStimulus(32'd100, 1'b0);
        waitDone("post", 33);
        checkOutput("post_bcd",     64'(bcd),     64'h100);
        checkOutput("post_ndigits", 64'(ndigits), 64'd3);
        start = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
